// File: rtl/nioslab2_pio_sensor.sv
// Avalon-MM sensor input port: synchronizes, debounces and edge-detects
// each feedback line, latching qualifying edges into a PIO-style capture register.
module nioslab2_pio_sensor #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr;

    assign wr  = chipselect && !write_n;
    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign irq = |(edge_capture & irq_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    always_comb begin
        update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            update[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // stable holds the previous level, so the new level is sync2
    always_comb begin
        qual = '0;
        if (EDGE_TYPE == 0) begin
            qual = update & sync2;
        end else if (EDGE_TYPE == 1) begin
            qual = update & ~sync2;
        end else begin
            qual = update;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (update[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // a new event on the same bit overrides a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= (edge_capture & ~clr) | qual;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0: readdata[WIDTH-1:0] = stable;
            2'd1: readdata = '0;
            2'd2: readdata[WIDTH-1:0] = irq_mask;
            2'd3: readdata[WIDTH-1:0] = edge_capture;
        endcase
    end

endmodule
